// File: rtl/dragster_pkg.sv
// Shared constants for the dragster SPI register responder: frame layout,
// register file geometry and the update-flag register location.
package dragster_pkg;

    localparam int NUM_REGS   = 16;
    localparam int FRAME_BITS = 16;
    localparam int BYTE_BITS  = FRAME_BITS / 2;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = $clog2(NUM_REGS);
    localparam int BIT_CNT_W  = $clog2(BYTE_BITS);
    localparam int RW_BIT     = 7;
    localparam int UPDATE_BIT = 7;

    localparam logic [ADDR_W-1:0] UPDATE_ADDR = 4'd1;

    // A committed write that raises the sticky update flag.
    function automatic logic is_update_write(input logic [ADDR_W-1:0] addr,
                                             input logic [DATA_W-1:0] data);
        return (addr == UPDATE_ADDR) && data[UPDATE_BIT];
    endfunction

endpackage

// File: rtl/dragster_spi_sync.sv
// Multi-bit flop synchronizer with rising/falling edge detection on the
// synchronized outputs; reset loads each bit with its idle level.
module dragster_spi_sync #(
    parameter int                 WIDTH     = 3,
    parameter int                 STAGES    = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]             prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= RESET_VAL;
            end
            prev <= RESET_VAL;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
        end
    end

    assign dout = chain[STAGES-1];
    assign rise = dout & ~prev;
    assign fall = ~dout & prev;

endmodule

// File: rtl/dragster_spi_responder.sv
// SPI mode-0 responder in front of a 16 x 8-bit register file: 16-bit frames
// of address byte (R/W in bit 7) followed by a data byte, all in the clk domain.
module dragster_spi_responder
    import dragster_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              update_done,
    output logic              frame_error
);

    localparam logic [1:0] IDLE          = 2'd0;
    localparam logic [1:0] ADDR          = 2'd1;
    localparam logic [1:0] DATA          = 2'd2;
    localparam logic [1:0] WAIT_DESELECT = 2'd3;

    logic [2:0] sync_out, sync_rise, sync_fall;

    dragster_spi_sync #(
        .WIDTH     (3),
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (3'b010)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({mosi, ss_n, sclk}),
        .dout    (sync_out),
        .rise    (sync_rise),
        .fall    (sync_fall)
    );

    logic sclk_rise, sclk_fall, ss_n_s, ss_n_fall, mosi_s;
    assign sclk_rise = sync_rise[0];
    assign sclk_fall = sync_fall[0];
    assign ss_n_s    = sync_out[1];
    assign ss_n_fall = sync_fall[1];
    assign mosi_s    = sync_out[2];

    logic unused_edges;
    assign unused_edges = &{1'b0, sync_rise[2:1], sync_fall[2], sync_out[0]};

    logic [1:0]           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-2:0]    shift_in;
    logic [DATA_W-1:0]    tx_shift;
    logic [ADDR_W-1:0]    frame_addr;
    logic                 is_read;
    logic                 armed;
    logic [SYNC_STAGES:0] flush;
    logic [DATA_W-1:0]    regs [NUM_REGS];

    logic [DATA_W-1:0] next_byte;
    logic              last_bit;
    assign next_byte = {shift_in, mosi_s};
    assign last_bit  = (bit_cnt == BIT_CNT_W'(BYTE_BITS - 1));

    // A frame may only start once ss_n has been seen high on real samples,
    // so a reset released mid-frame cannot mistake the flushed synchronizer
    // for a select edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_in    <= '0;
            tx_shift    <= '0;
            frame_addr  <= '0;
            is_read     <= 1'b0;
            armed       <= 1'b0;
            flush       <= '0;
            miso        <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_error <= 1'b0;
        end else begin
            wr_valid    <= 1'b0;
            frame_error <= 1'b0;
            flush       <= {flush[SYNC_STAGES-1:0], 1'b1};
            if (flush[SYNC_STAGES] && ss_n_s) begin
                armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (armed && ss_n_fall) begin
                        state   <= ADDR;
                        bit_cnt <= '0;
                    end
                end
                ADDR: begin
                    miso <= 1'b0;
                    if (ss_n_s) begin
                        state       <= IDLE;
                        frame_error <= 1'b1;
                    end else if (sclk_rise) begin
                        shift_in <= next_byte[DATA_W-2:0];
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            state      <= DATA;
                            bit_cnt    <= '0;
                            is_read    <= next_byte[RW_BIT];
                            frame_addr <= next_byte[ADDR_W-1:0];
                            tx_shift   <= next_byte[RW_BIT] ? regs[next_byte[ADDR_W-1:0]] : '0;
                        end
                    end
                end
                DATA: begin
                    if (ss_n_s) begin
                        state       <= IDLE;
                        miso        <= 1'b0;
                        frame_error <= 1'b1;
                    end else begin
                        if (sclk_fall) begin
                            miso     <= tx_shift[DATA_W-1];
                            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            shift_in <= next_byte[DATA_W-2:0];
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (last_bit) begin
                                state <= WAIT_DESELECT;
                                if (!is_read) begin
                                    wr_valid <= 1'b1;
                                    wr_addr  <= frame_addr;
                                    wr_data  <= next_byte;
                                end
                            end
                        end
                    end
                end
                default: begin
                    miso <= 1'b0;
                    if (ss_n_s) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Register file updates at the end of the wr_valid cycle, so a local read
    // of the committed address sees the old value during that cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            update_done <= 1'b0;
        end else if (wr_valid) begin
            regs[wr_addr] <= wr_data;
            if (is_update_write(wr_addr, wr_data)) begin
                update_done <= 1'b1;
            end
        end
    end

    assign rd_data = regs[rd_addr];

endmodule

// File: doc/dragster_spi_responder.md
DRAGSTER_SPI_RESPONDER -- requirements
Module: dragster_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for sclk, ss_n and mosi.
REQ-002 SHALL have port clk  input  1  system clock; must run at least 8x the sclk frequency.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sclk  input  1  SPI clock from the master, asynchronous to clk.
REQ-005 SHALL have port ss_n  input  1  slave select from the master, active-low.
REQ-006 SHALL have port mosi  input  1  master-out serial data.
REQ-007 SHALL have port miso  output  1  slave-out serial data.
REQ-008 SHALL have port wr_valid  output  1  one-clk pulse on each committed register write.
REQ-009 SHALL have port wr_addr  output  4  address of the committed write.
REQ-010 SHALL have port wr_data  output  8  data of the committed write.
REQ-011 SHALL have port rd_addr  input  4  local read address.
REQ-012 SHALL have port rd_data  output  8  combinational contents of register rd_addr.
REQ-013 SHALL have port update_done  output  1  sticky flag: register 1 written with bit 7 set.
REQ-014 SHALL have port frame_error  output  1  one-clk pulse when a frame aborts.

Function
REQ-015 SHALL synchronize sclk, ss_n and mosi through SYNC_STAGES flops and detect sclk edges in the clk domain.
REQ-016 SHALL use SPI mode 0: sample mosi on the sclk rising edge and update miso on the sclk falling edge, MSB first.
REQ-017 SHALL use a 16-bit frame: byte 1 is the address byte (bit 7 = R/W, 1 = read; bits 3:0 = address; bits 6:4 ignored), and byte 2 is the data byte.
REQ-018 SHALL use the FSM states IDLE, ADDR, DATA and WAIT_DESELECT.
REQ-019 SHALL go from IDLE to ADDR on a synchronized ss_n falling edge, clearing the bit counter.
REQ-020 SHALL go from ADDR to DATA after 8 rising sclk edges and latch the address and R/W bit.
REQ-021 SHALL go from DATA to WAIT_DESELECT after 8 more rising edges; a write frame commits here.
REQ-022 SHALL go from WAIT_DESELECT to IDLE on ss_n high; sclk edges seen in WAIT_DESELECT are ignored.
REQ-023 SHALL hold a register file of 16 x 8-bit registers, all reset to 0x00.
REQ-024 SHALL commit a write one clk after the 16th rising sclk edge, pulsing wr_valid with wr_addr and wr_data for exactly one clk.
REQ-025 SHALL, for a read frame, load the addressed register at the ADDR->DATA transition and shift it out on miso during the data byte; the received data byte is discarded and no write occurs.
REQ-026 SHALL drive miso to 0 in IDLE, in ADDR and in WAIT_DESELECT.
REQ-027 SHALL abort a frame whenever ss_n rises in ADDR or DATA: no write, frame_error pulses for one clk, and the FSM returns to IDLE.
REQ-028 SHALL set update_done when address 1 is written with data bit 7 = 1; the flag stays set until reset.
REQ-029 SHALL let a local rd_addr read of the same register being committed return the old value in that clk and the new value in the next clk.

Reset
REQ-030 SHALL, on reset_n low, immediately clear the FSM to IDLE, the counter to 0, all registers to 0x00, miso, wr_valid, update_done and frame_error to 0, and the synchronizers to the idle levels (sclk 0, ss_n 1).
REQ-031 SHALL, when reset is released mid-frame, ignore the remainder of that frame until ss_n has been seen high.

Structure
REQ-032 SHALL place the register count (16), the frame width (16), the R/W bit index, the update register address (1) and the update bit index in the shared dragster package.
REQ-033 SHALL use one sub-module, dragster_spi_sync (a parameterized multi-bit synchronizer with edge detect), for sclk, ss_n and mosi.

Verification
REQ-034 SHALL cover: five write frames {0x05,0x3B},{0x02,0x23},{0x03,0xEB},{0x09,0x1F},{0x01,0xA1} -> the registers hold those values, wr_valid pulses 5 times, and update_done=1 after the last frame.
REQ-035 SHALL cover: after REQ-034, a read frame with address byte 0x83 -> miso shifts 0xEB MSB first during the data byte, and register 3 is unchanged.
REQ-036 SHALL cover: ss_n raised after 11 bits of frame {0x04,0x55} -> frame_error pulses once, there is no wr_valid, and register 4 stays 0x00.
REQ-037 SHALL cover: reset_n pulsed low mid-DATA -> all registers are 0x00 and update_done=0; the next full frame {0x02,0x7E} then writes correctly.
REQ-038 SHALL cover: 20 sclk pulses in one selection for frame {0x06,0xC3} -> exactly one write of 0xC3 to register 6, with the trailing bits ignored.
REQ-039 SHALL cover: write {0x01,0x21} (bit 7 clear) -> register 1 = 0x21 and update_done stays 0.
